// File: rtl/four_bit_1x2_demux_stream_pkg.sv
// Shared widths and slot state encoding for the four-bit 1-to-2 streaming demux.
package four_bit_1x2_demux_stream_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_CNT_W = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/four_bit_1x2_demux_stream_slot.sv
// One-entry output slot: register slice, EMPTY/FULL FSM and delivered-word counter.
module four_bit_1x2_demux_stream_slot
  import four_bit_1x2_demux_stream_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Fill,
  input  logic [WIDTH-1:0] Data_In,
  input  logic             Ready,
  output logic [WIDTH-1:0] Data_Out,
  output logic             Valid,
  output logic [CNT_W-1:0] Count,
  output logic             Can_Fill
);

  slot_state_t state, state_next;
  logic        drain;

  assign Valid    = (state == FULL);
  assign drain    = Valid && Ready;
  // A full slot can take a new word only in the cycle its current word leaves.
  assign Can_Fill = (state == EMPTY) || drain;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (Fill) state_next = FULL;
      FULL:  if (drain && !Fill) state_next = EMPTY;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Data_Out <= '0;
      Count    <= '0;
    end else begin
      if (Fill) Data_Out <= Data_In;
      if (drain) Count <= Count + 1'b1;
    end
  end

endmodule

// File: rtl/four_bit_1x2_demux_stream.sv
// Streaming 1-to-2 demux: steers each accepted input word into one of two output slots.
module four_bit_1x2_demux_stream
  import four_bit_1x2_demux_stream_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] In,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic             Select,
  output logic [WIDTH-1:0] Out_0,
  output logic             Out_0_Valid,
  input  logic             Out_0_Ready,
  output logic [WIDTH-1:0] Out_1,
  output logic             Out_1_Valid,
  input  logic             Out_1_Ready,
  output logic [CNT_W-1:0] Count_0,
  output logic [CNT_W-1:0] Count_1
);

  logic can_fill_0, can_fill_1;
  logic accept, fill_0, fill_1;

  // Ready looks only at the selected slot, so it never depends on In_Valid.
  assign In_Ready = Rst_n && (Select ? can_fill_1 : can_fill_0);
  assign accept   = In_Valid && In_Ready;
  assign fill_0   = accept && !Select;
  assign fill_1   = accept && Select;

  four_bit_1x2_demux_stream_slot #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_slot_0 (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Fill    (fill_0),
    .Data_In (In),
    .Ready   (Out_0_Ready),
    .Data_Out(Out_0),
    .Valid   (Out_0_Valid),
    .Count   (Count_0),
    .Can_Fill(can_fill_0)
  );

  four_bit_1x2_demux_stream_slot #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_slot_1 (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Fill    (fill_1),
    .Data_In (In),
    .Ready   (Out_1_Ready),
    .Data_Out(Out_1),
    .Valid   (Out_1_Valid),
    .Count   (Count_1),
    .Can_Fill(can_fill_1)
  );

endmodule

// File: tb/tb_four_bit_1x2_demux_stream.sv
// Self-checking bench: directed vector table, reset/wrap sequences, random run against a queue model.
module tb_four_bit_1x2_demux_stream;

  logic       Clk;
  logic       Rst_n;
  logic [3:0] In;
  logic       In_Valid;
  logic       In_Ready;
  logic       Select;
  logic [3:0] Out_0;
  logic       Out_0_Valid;
  logic       Out_0_Ready;
  logic [3:0] Out_1;
  logic       Out_1_Valid;
  logic       Out_1_Ready;
  logic [7:0] Count_0;
  logic [7:0] Count_1;

  int errors = 0;
  int checks = 0;

  logic [3:0] q0[$];
  logic [3:0] q1[$];
  int cnt0 = 0;
  int cnt1 = 0;

  typedef struct {
    logic [3:0] din;
    logic       sel;
    logic       iv;
    logic       r0;
    logic       r1;
    logic       exp_ready;
    logic       exp_v0;
    logic [3:0] exp_d0;
    logic       exp_v1;
    logic [3:0] exp_d1;
    logic [7:0] exp_c0;
    logic [7:0] exp_c1;
  } vec_t;

  vec_t vecs[12];

  four_bit_1x2_demux_stream #(.WIDTH(4), .CNT_W(8)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .In         (In),
    .In_Valid   (In_Valid),
    .In_Ready   (In_Ready),
    .Select     (Select),
    .Out_0      (Out_0),
    .Out_0_Valid(Out_0_Valid),
    .Out_0_Ready(Out_0_Ready),
    .Out_1      (Out_1),
    .Out_1_Valid(Out_1_Valid),
    .Out_1_Ready(Out_1_Ready),
    .Count_0    (Count_0),
    .Count_1    (Count_1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, required);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] d, input logic s, input logic iv,
                               input logic rd0, input logic rd1);
    In          = d;
    Select      = s;
    In_Valid    = iv;
    Out_0_Ready = rd0;
    Out_1_Ready = rd1;
  endtask

  // A slot is a queue of at most one word; the selected slot accepts when empty or leaving.
  function automatic logic modelReady();
    if (Select) return (q1.size() == 0) || Out_1_Ready;
    return (q0.size() == 0) || Out_0_Ready;
  endfunction

  task automatic advance();
    logic       acc, dr0, dr1, sel;
    logic [3:0] d;
    logic [3:0] junk;
    acc = In_Valid && modelReady();
    dr0 = (q0.size() != 0) && Out_0_Ready;
    dr1 = (q1.size() != 0) && Out_1_Ready;
    sel = Select;
    d   = In;
    @(posedge Clk);
    #1;
    if (dr0) begin
      junk = q0.pop_front();
      cnt0 = (cnt0 + 1) % 256;
    end
    if (dr1) begin
      junk = q1.pop_front();
      cnt1 = (cnt1 + 1) % 256;
    end
    if (acc) begin
      if (sel) q1.push_back(d);
      else q0.push_back(d);
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_in_ready"}, int'(In_Ready), int'(modelReady()));
    check({tag, "_v0"}, int'(Out_0_Valid), int'(q0.size() != 0));
    if (q0.size() != 0) check({tag, "_d0"}, int'(Out_0), int'(q0[0]));
    check({tag, "_c0"}, int'(Count_0), cnt0);
    check({tag, "_v1"}, int'(Out_1_Valid), int'(q1.size() != 0));
    if (q1.size() != 0) check({tag, "_d1"}, int'(Out_1), int'(q1[0]));
    check({tag, "_c1"}, int'(Count_1), cnt1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int stalls;
    vecs[0]  = '{4'b1010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1010, 1'b0, 4'b0000, 8'd0, 8'd0};
    vecs[1]  = '{4'b0101, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1010, 1'b1, 4'b0101, 8'd1, 8'd0};
    vecs[2]  = '{4'b1111, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1010, 1'b1, 4'b1111, 8'd1, 8'd1};
    vecs[3]  = '{4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010, 1'b1, 4'b1111, 8'd1, 8'd1};
    vecs[4]  = '{4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010, 1'b1, 4'b1111, 8'd1, 8'd1};
    vecs[5]  = '{4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1010, 1'b1, 4'b0000, 8'd1, 8'd2};
    vecs[6]  = '{4'b0011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0011, 1'b1, 4'b0000, 8'd1, 8'd2};
    vecs[7]  = '{4'b1100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0011, 1'b1, 4'b0000, 8'd2, 8'd2};
    vecs[8]  = '{4'b1001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0011, 1'b1, 4'b0000, 8'd2, 8'd2};
    vecs[9]  = '{4'b1001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0011, 1'b0, 4'b0000, 8'd2, 8'd3};
    vecs[10] = '{4'b0110, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0, 4'b0000, 8'd2, 8'd3};
    vecs[11] = '{4'b1011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0110, 1'b1, 4'b1011, 8'd2, 8'd3};

    Rst_n = 1'b0;
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge Clk);
    #1;
    check("reset_v0", int'(Out_0_Valid), 0);
    check("reset_v1", int'(Out_1_Valid), 0);
    check("reset_in_ready", int'(In_Ready), 0);
    Rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].din, vecs[i].sel, vecs[i].iv, vecs[i].r0, vecs[i].r1);
      @(negedge Clk);
      check($sformatf("vec%0d_in_ready", i), int'(In_Ready), int'(vecs[i].exp_ready));
      advance();
      check($sformatf("vec%0d_v0", i), int'(Out_0_Valid), int'(vecs[i].exp_v0));
      check($sformatf("vec%0d_d0", i), int'(Out_0), int'(vecs[i].exp_d0));
      check($sformatf("vec%0d_v1", i), int'(Out_1_Valid), int'(vecs[i].exp_v1));
      check($sformatf("vec%0d_d1", i), int'(Out_1), int'(vecs[i].exp_d1));
      check($sformatf("vec%0d_c0", i), int'(Count_0), int'(vecs[i].exp_c0));
      check($sformatf("vec%0d_c1", i), int'(Count_1), int'(vecs[i].exp_c1));
    end

    // Both slots are full with nonzero counters; reset must clear everything without a clock edge.
    #2;
    Rst_n = 1'b0;
    applyStimulus(4'b0111, 1'b0, 1'b1, 1'b1, 1'b1);
    #1;
    check("async_rst_in_ready", int'(In_Ready), 0);
    check("async_rst_v0", int'(Out_0_Valid), 0);
    check("async_rst_d0", int'(Out_0), 0);
    check("async_rst_c0", int'(Count_0), 0);
    check("async_rst_v1", int'(Out_1_Valid), 0);
    check("async_rst_d1", int'(Out_1), 0);
    check("async_rst_c1", int'(Count_1), 0);
    q0.delete();
    q1.delete();
    cnt0 = 0;
    cnt1 = 0;
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    applyStimulus(4'b1110, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge Clk);
    check("post_rst_in_ready", int'(In_Ready), 1);
    advance();
    check("post_rst_v0", int'(Out_0_Valid), 1);
    check("post_rst_d0", int'(Out_0), 4'b1110);

    // Back-to-back stream into slot 0; the counter must pass 255 and wrap to 0.
    stalls = 0;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(4'(i), 1'b0, 1'b1, 1'b1, 1'b0);
      @(negedge Clk);
      if (!In_Ready) stalls++;
      advance();
      if (i == 254) check("wrap_c0_255", int'(Count_0), 255);
      if (i == 255) check("wrap_c0_0", int'(Count_0), 0);
    end
    check("wrap_stalls", stalls, 0);
    check("wrap_last_d0", int'(Out_0), 4'b1111);
    check("wrap_c1", int'(Count_1), 0);

    for (int i = 0; i < 1000; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) < 3),
                    1'($urandom_range(0, 4) < 3));
      In_Valid = ~In_Valid;
      #1;
      check($sformatf("rand%0d_ready_indep", i), int'(In_Ready), int'(modelReady()));
      In_Valid = ~In_Valid;
      #1;
      @(negedge Clk);
      checkOutput($sformatf("rand%0d", i));
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
